// File: rtl/bp_sac_coh_link_arbiter.sv
// rtl/bp_sac_coh_link_arbiter.sv - wormhole-aware round-robin arbiter sharing one coherence ready_and link
module bp_sac_coh_link_arbiter #(
    parameter int num_req_p    = 4,
    parameter int flit_width_p = 64,
    parameter int cord_width_p = 8,
    parameter int len_width_p  = 4
) (
    input  logic                                coh_clk_i,
    input  logic                                coh_reset_n_i,
    input  logic [num_req_p-1:0]                req_en_i,
    input  logic [num_req_p-1:0]                req_v_i,
    input  logic [num_req_p*flit_width_p-1:0]   req_data_i,
    output logic [num_req_p-1:0]                req_ready_and_o,
    output logic                                link_v_o,
    output logic [flit_width_p-1:0]             link_data_o,
    input  logic                                link_ready_and_i,
    output logic [num_req_p-1:0]                grant_o,
    output logic                                busy_o
);

    localparam int ptr_w = $clog2(num_req_p);

    typedef enum logic {IDLE, BUSY} state_e;

    state_e                  state_r, state_n;
    logic [len_width_p-1:0]  cnt_r, cnt_n;
    logic [ptr_w-1:0]        owner_r, owner_n;
    logic [ptr_w-1:0]        last_ptr_r, last_ptr_n;

    logic [num_req_p-1:0]    eligible;
    logic                    found;
    logic [ptr_w-1:0]        winner;
    logic [ptr_w-1:0]        scan_idx;
    logic [ptr_w-1:0]        sel;
    logic [flit_width_p-1:0] sel_flit;
    logic [len_width_p-1:0]  hdr_len;
    logic                    xfer;

    assign eligible = req_v_i & req_en_i;

    // Round-robin scan starting just after the last packet's owner
    always_comb begin
        found    = 1'b0;
        winner   = '0;
        scan_idx = '0;
        for (int k = 1; k <= num_req_p; k++) begin
            scan_idx = ptr_w'((int'(last_ptr_r) + k) % num_req_p);
            if (!found && eligible[scan_idx]) begin
                found  = 1'b1;
                winner = scan_idx;
            end
        end
    end

    assign sel = (state_r == BUSY) ? owner_r : winner;

    always_comb begin
        sel_flit = '0;
        for (int i = 0; i < num_req_p; i++) begin
            if (sel == ptr_w'(i)) begin
                sel_flit = req_data_i[i*flit_width_p +: flit_width_p];
            end
        end
    end

    assign hdr_len = sel_flit[cord_width_p +: len_width_p];
    assign xfer    = link_v_o & link_ready_and_i;

    always_ff @(posedge coh_clk_i or negedge coh_reset_n_i) begin
        if (!coh_reset_n_i) begin
            state_r    <= IDLE;
            cnt_r      <= '0;
            owner_r    <= '0;
            last_ptr_r <= ptr_w'(num_req_p - 1);
        end else begin
            state_r    <= state_n;
            cnt_r      <= cnt_n;
            owner_r    <= owner_n;
            last_ptr_r <= last_ptr_n;
        end
    end

    always_comb begin
        state_n    = state_r;
        cnt_n      = cnt_r;
        owner_n    = owner_r;
        last_ptr_n = last_ptr_r;
        case (state_r)
            IDLE: begin
                if (xfer) begin
                    if (hdr_len == '0) begin
                        last_ptr_n = winner;
                    end else begin
                        cnt_n   = hdr_len;
                        owner_n = winner;
                        state_n = BUSY;
                    end
                end
            end
            BUSY: begin
                if (xfer) begin
                    cnt_n = cnt_r - 1'b1;
                    if (cnt_r == len_width_p'(1)) begin
                        state_n    = IDLE;
                        last_ptr_n = owner_r;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // Outputs are forced low while reset is asserted, independent of the clock
    always_comb begin
        link_v_o        = 1'b0;
        link_data_o     = '0;
        grant_o         = '0;
        req_ready_and_o = '0;
        busy_o          = 1'b0;
        if (coh_reset_n_i) begin
            if (state_r == BUSY) begin
                busy_o                   = 1'b1;
                link_v_o                 = req_v_i[owner_r];
                link_data_o              = sel_flit;
                grant_o[owner_r]         = 1'b1;
                req_ready_and_o[owner_r] = link_ready_and_i;
            end else if (found) begin
                link_v_o                = 1'b1;
                link_data_o             = sel_flit;
                grant_o[winner]         = 1'b1;
                req_ready_and_o[winner] = link_ready_and_i;
            end
        end
    end

endmodule
